// File: rtl/fft_bitrev_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg : shared constants and types for the FFT output reorder buffer.
//   N_LOG2 / N : FFT length (256 points)
//   DW         : width of each real and imaginary component
//   cplx_t     : packed complex sample {re, im}, two's complement
//   bitrev     : reverses all N_LOG2 bits of an index
//   RD_IDLE / RD_RUN : read-side FSM state encodings
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int N_LOG2 = 8;
  localparam int N      = 1 << N_LOG2;
  localparam int DW     = 16;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_RUN  = 1'b1;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int b = 0; b < N_LOG2; b++) r[b] = a[N_LOG2-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder_if : streaming bus of the FFT reorder buffer.
//   in_valid/in_sof/in_r/in_i      : bit-reversed input stream (no backpressure)
//   out_valid/out_sof/out_eof/...  : natural-order output stream with markers
//   frame_err                      : one-cycle pulse when in_sof forces a resync
// Modports: slave = the reorder block, master = the upstream/downstream side.
// -----------------------------------------------------------------------------
interface fft_bitrev_reorder_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic                 out_valid;
  logic                 out_sof;
  logic                 out_eof;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic                 frame_err;

  modport slave (
    input  in_valid, in_sof, in_r, in_i,
    output out_valid, out_sof, out_eof, out_r, out_i, frame_err
  );

  modport master (
    output in_valid, in_sof, in_r, in_i,
    input  out_valid, out_sof, out_eof, out_r, out_i, frame_err
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// -----------------------------------------------------------------------------
// fft_pingpong_ram : two banks of N complex words, one synchronous write port
// and one synchronous read port (1-cycle read latency). The bank bit is the
// address MSB. Storage is never reset.
//   clk_i                       : clock
//   we_i, wbank_i, waddr_i, wdata_i : write port
//   rbank_i, raddr_i, rdata_o   : read port (rdata_o valid one cycle later)
// -----------------------------------------------------------------------------
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [N_LOG2-1:0] waddr_i,
  input  cplx_t             wdata_i,
  input  logic              rbank_i,
  input  logic [N_LOG2-1:0] raddr_i,
  output cplx_t             rdata_o
);

  cplx_t mem_q [0:2*N-1];
  cplx_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[{wbank_i, waddr_i}] <= wdata_i;
    rdata_q <= mem_q[{rbank_i, raddr_i}];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder : reorders one 256-point FFT frame per N valid inputs from
// bit-reversed to natural order through a ping-pong RAM, at full rate with no
// backpressure. Output is N contiguous cycles starting two cycles after the
// edge that captures the last input sample.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : fft_bitrev_reorder_if.slave (input stream, output stream,
//              frame_err resync pulse)
// Build option: FFT_REORDER_FFTSHIFT_EN -> output order N/2..N-1, 0..N/2-1
// (DC centred); out_sof/out_eof still mark the first/last emitted bin.
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
  import fft_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  fft_bitrev_reorder_if.slave bus
);

  localparam logic [N_LOG2-1:0] LAST = '1;

  logic [N_LOG2-1:0] wcnt_q, wcnt_d;
  logic              wbank_q, wbank_d;
  logic [N_LOG2-1:0] waddr;
  logic              rd_req;
  logic              ferr_d, ferr_q;
  cplx_t             wdata;

  rd_state_t         state_q, state_d;
  logic [N_LOG2-1:0] rcnt_q, rcnt_d;
  logic              rbank_q, rbank_d;
  logic              pend_q, pend_d;
  logic [N_LOG2-1:0] raddr_p0;

  logic              vld_p1, sof_p1, eof_p1;
  cplx_t             rdata_p1;

  logic              out_vld_q, out_sof_q, out_eof_q;
  cplx_t             out_data_q, out_data_d;

  assign wdata.re = bus.in_r;
  assign wdata.im = bus.in_i;

  // Write side: bit-reversed addressing; an in_sof mid-frame restarts the
  // frame at address 0 in the same bank.
  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    waddr   = bitrev(wcnt_q);
    rd_req  = 1'b0;
    ferr_d  = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof && (wcnt_q != '0)) begin
        waddr  = '0;
        wcnt_d = N_LOG2'(1);
        ferr_d = 1'b1;
      end else if (wcnt_q == LAST) begin
        wcnt_d  = '0;
        wbank_d = ~wbank_q;
        rd_req  = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // Read FSM: a request during a run waits in pend_q; at the end of a run a
  // pending or same-cycle request chains straight onto the other bank.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    pend_d  = pend_q;
    case (state_q)
      RD_IDLE: begin
        if (rd_req) begin
          state_d = RD_RUN;
          rcnt_d  = '0;
          rbank_d = wbank_q;
        end
      end
      default: begin
        if (rcnt_q == LAST) begin
          if (pend_q || rd_req) begin
            rcnt_d  = '0;
            rbank_d = ~rbank_q;
            pend_d  = 1'b0;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
          if (rd_req) pend_d = 1'b1;
        end
      end
    endcase
  end

`ifdef FFT_REORDER_FFTSHIFT_EN
  assign raddr_p0 = {~rcnt_q[N_LOG2-1], rcnt_q[N_LOG2-2:0]};
`else
  assign raddr_p0 = rcnt_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      ferr_q  <= 1'b0;
      state_q <= RD_IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      ferr_q  <= ferr_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
      pend_q  <= pend_d;
    end
  end

  fft_pingpong_ram u_ram (
    .clk_i   (CLK),
    .we_i    (bus.in_valid),
    .wbank_i (wbank_q),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rbank_i (rbank_q),
    .raddr_i (raddr_p0),
    .rdata_o (rdata_p1)
  );

  // p0 -> p1: markers travel alongside the RAM read latency
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      vld_p1 <= (state_q == RD_RUN);
      sof_p1 <= (state_q == RD_RUN) && (rcnt_q == '0);
      eof_p1 <= (state_q == RD_RUN) && (rcnt_q == LAST);
    end
  end

  // p1 -> output register
  assign out_data_d = vld_p1 ? rdata_p1 : out_data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_vld_q  <= 1'b0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= vld_p1;
      out_sof_q  <= sof_p1;
      out_eof_q  <= eof_p1;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.out_r     = out_data_q.re;
  assign bus.out_i     = out_data_q.im;
  assign bus.frame_err = ferr_q;

  // Banks alternate and a frame takes at least N cycles, so a second request
  // can never arrive while one is already pending.
  a_single_pending: assert property (@(posedge CLK) disable iff (RST) !(rd_req && pend_q));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SHIFT = 128;
`else
  localparam int SHIFT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if bus();
  fft_bitrev_reorder dut (.CLK(clk), .RST(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    bit sof;
    bit eof;
    int cyc;
  } obs_t;

  obs_t oq[$];
  int   ferr_cnt = 0;
  int   ferr_cyc = -1;
  int   bad_flag = 0;
  int   exp_re[4][256];
  int   exp_im[4][256];

  always @(negedge clk) begin : collect
    obs_t o;
    if (bus.out_valid === 1'b1) begin
      o.re = bus.out_r;
      o.im = bus.out_i;
      o.sof = bus.out_sof;
      o.eof = bus.out_eof;
      o.cyc = cyc;
      oq.push_back(o);
    end else if (bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0) begin
      bad_flag++;
    end
    if (bus.frame_err === 1'b1) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  end

  function automatic int brv(input int k);
    int r = 0;
    for (int b = 0; b < 8; b++) if (k[b]) r |= (1 << (7 - b));
    return r;
  endfunction

  task automatic drive_idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sample(input int re, input int im, input bit sof);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_r     = re[15:0];
    bus.in_i     = im[15:0];
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // Feeds frame f of the expectation table in bit-reversed order.
  task automatic feed_frame(input int f, input bit gapped, output int t_last);
    for (int k = 0; k < 256; k++) begin
      if (gapped) repeat ($urandom_range(0, 2)) drive_idle(1);
      drive_sample(exp_re[f][brv(k)], exp_im[f][brv(k)], k == 0);
    end
    t_last = cyc;
  endtask

  task automatic check_out(input string name, input int nfr, input int first_cyc);
    int need;
    obs_t o;
    int bin, er, ei, ec;
    bit es, ee;
    need = nfr * 256;
    for (int c = 0; c < need + 2000 && oq.size() < need; c++) @(negedge clk);
    checks++;
    if (oq.size() < need) begin
      errors++;
      $display("FAIL %s timeout: got %0d outputs, required %0d", name, oq.size(), need);
    end else begin
      for (int f = 0; f < nfr; f++) begin
        for (int j = 0; j < 256; j++) begin
          o   = oq[f * 256 + j];
          bin = j ^ SHIFT;
          er  = exp_re[f][bin];
          ei  = exp_im[f][bin];
          es  = (j == 0);
          ee  = (j == 255);
          ec  = first_cyc + f * 256 + j;
          checks++;
          if (o.re !== er || o.im !== ei || o.sof !== es || o.eof !== ee || o.cyc !== ec) begin
            errors++;
            $display("FAIL %s f%0d out%0d: got re=%0d im=%0d sof=%0b eof=%0b cyc=%0d, required re=%0d im=%0d sof=%0b eof=%0b cyc=%0d",
                     name, f, j, o.re, o.im, o.sof, o.eof, o.cyc, er, ei, es, ee, ec);
          end
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (oq.size() != need) begin
      errors++;
      $display("FAIL %s count: got %0d outputs, required %0d", name, oq.size(), need);
    end
    oq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp(input int base, input int imul);
    for (int b = 0; b < 256; b++) begin
      exp_re[0][b] = base + b;
      exp_im[0][b] = imul * b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle(3);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.out_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b required 0", bus.out_sof); end
    checks++; if (bus.out_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b required 0", bus.out_eof); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b required 0", bus.frame_err); end
    checks++; if (bus.out_r !== 16'sd0) begin errors++; $display("FAIL reset_r: got %0d required 0", bus.out_r); end
    checks++; if (bus.out_i !== 16'sd0) begin errors++; $display("FAIL reset_i: got %0d required 0", bus.out_i); end
    rst = 1'b0;
    drive_idle(2);
  endtask

  task automatic test_impulse();
    int t;
    for (int b = 0; b < 256; b++) begin
      exp_re[0][b] = 0;
      exp_im[0][b] = 0;
    end
    exp_re[0][0] = 100;
    exp_im[0][0] = -100;
    ferr_cnt = 0;
    feed_frame(0, 1'b0, t);
    check_out("impulse", 1, t + 2);
    checks++;
    if (ferr_cnt !== 0) begin errors++; $display("FAIL impulse_ferr: got %0d pulses required 0", ferr_cnt); end
  endtask

  task automatic test_ramp();
    int t;
    fill_ramp(0, -1);
    feed_frame(0, 1'b0, t);
    check_out("ramp", 1, t + 2);
  endtask

  task automatic test_gapped();
    int t;
    fill_ramp(0, -1);
    feed_frame(0, 1'b1, t);
    check_out("gapped", 1, t + 2);
  endtask

  task automatic test_back_to_back();
    int t0, t;
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 256; b++) begin
        exp_re[f][b] = f * 256 + b;
        exp_im[f][b] = b - f;
      end
    feed_frame(0, 1'b0, t0);
    for (int f = 1; f < 4; f++) feed_frame(f, 1'b0, t);
    drive_idle(1);
    check_out("back_to_back", 4, t0 + 2);
  endtask

  task automatic test_resync();
    int t, e;
    fill_ramp(0, -1);
    ferr_cnt = 0;
    ferr_cyc = -1;
    for (int k = 0; k < 37; k++) drive_sample(777, -777, k == 0);
    e = cyc + 1;
    feed_frame(0, 1'b0, t);
    checks++;
    if (ferr_cnt !== 1) begin errors++; $display("FAIL resync_ferr_count: got %0d pulses required 1", ferr_cnt); end
    checks++;
    if (ferr_cyc !== e) begin errors++; $display("FAIL resync_ferr_cycle: got %0d required %0d", ferr_cyc, e); end
    check_out("resync", 1, t + 2);
  endtask

  task automatic test_reset_mid_read();
    int t, n;
    fill_ramp(0, -1);
    feed_frame(0, 1'b0, t);
    for (int c = 0; c < 600 && oq.size() < 101; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    n = oq.size();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (n < 101 || oq[100].re !== (100 ^ SHIFT)) begin
      errors++;
      $display("FAIL midreset_progress: got %0d outputs before reset, required at least 101 with out100 re=%0d", n, 100 ^ SHIFT);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle(300);
    checks++;
    if (oq.size() !== n) begin errors++; $display("FAIL midreset_silent: got %0d outputs, required %0d", oq.size(), n); end
    oq.delete();
    fill_ramp(500, 2);
    feed_frame(0, 1'b0, t);
    check_out("after_reset", 1, t + 2);
  endtask

  task automatic test_flags();
    checks++;
    if (bad_flag !== 0) begin errors++; $display("FAIL flags_idle: got %0d marker cycles without valid, required 0", bad_flag); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_r     = '0;
    bus.in_i     = '0;
    test_reset();
    test_impulse();
    test_ramp();
    test_gapped();
    test_back_to_back();
    test_resync();
    test_reset_mid_read();
    test_flags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer directly downstream of the last FFT butterfly/twiddle stage of the 256-point radix-2^2 SDF pipeline.
- Accepts FFT bins in bit-reversed order, one complex sample per valid cycle, and emits them in natural order (bin 0..N-1) with frame markers.
- Ping-pong memory allows continuous back-to-back frames at full rate with no backpressure, matching the streaming, non-stallable pipeline.

Parameters:
- N_LOG2, 8, log2 of FFT length N (N = 256)
- DW, 16, bit width of each real and each imaginary component

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_sof  in  1  first sample of frame (bit-reversed index 0); qualified by in_valid
- in_r  in  DW  input real part, two's complement
- in_i  in  DW  input imaginary part, two's complement
- out_valid  out  1  output sample valid
- out_sof  out  1  high with bin 0 (or first shifted bin, see feature)
- out_eof  out  1  high with last output bin of the frame
- out_r  out  DW  output real part
- out_i  out  DW  output imaginary part
- frame_err  out  1  one-cycle pulse on frame resync

Behaviour:
- Reset (async): out_valid, out_sof, out_eof, frame_err, out_r, out_i = 0. Write count = 0, write bank = 0, reader idle. RAM contents are not cleared.
- Write side:
  - Each in_valid cycle stores {in_r, in_i} to wbank[bitrev(wcnt)], then wcnt++.
  - bitrev reverses all N_LOG2 bits.
  - When wcnt = N-1 is written: wcnt wraps to 0, the bank is marked full, the write bank toggles, and a read of the full bank is requested.
- Gaps: in_valid may drop at any point; wcnt holds. There is no timeout.
- in_sof:
  - With wcnt = 0: normal start.
  - With wcnt != 0: discard the partial frame, store this sample at address 0, set wcnt = 1, and pulse frame_err for 1 cycle. The write bank does not toggle.
  - A frame started without in_sof is still accepted; in_sof is a resync aid only.
- Read side FSM:
  - RD_IDLE -> RD_RUN on read request.
  - RD_RUN issues natural addresses 0..N-1, one per cycle, to the sync RAM (1-cycle read latency). The output register adds 1 more cycle.
  - RD_RUN -> RD_IDLE after address N-1, unless a new request is pending, in which case it goes straight to RD_RUN on the other bank with no bubble.
- Latency: the input capturing sample N-1 is at edge t. Read address 0 is issued at t+1. Bin 0 appears on out_* with out_valid=1 after edge t+2. Output is contiguous for N cycles (t+2..t+N+1).
- out_sof is high only with the first output sample; out_eof only with the last. Both are 0 whenever out_valid=0.
- Bank safety: at input rate <= 1 sample/cycle, the next write to a bank begins no earlier than t+N+1, after its last read address (t+N). No overflow condition exists.
  - A request arriving while RD_RUN is active is latched in a 1-deep pending flag.
  - A second request while the flag is already set is impossible by construction; assertion only.
- Reset mid-operation: the frame in flight is lost. Output goes silent immediately and the next frame restarts cleanly from wcnt = 0.
- Arithmetic: pass-through only. No width change, no rounding.

Optional Feature:
- Macro FFT_REORDER_FFTSHIFT_EN.
- Defined: the read address is the natural index with its MSB inverted. Output order is bins N/2..N-1 then 0..N/2-1 (fftshift, DC centred). out_sof marks bin N/2; out_eof marks bin N/2-1. Latency is unchanged.
- Undefined: plain natural order 0..N-1.

Decomposition:
- Shared package fft_pkg: N_LOG2, N, DW constants; complex sample typedef {re, im}; bitrev function; read FSM state enum.
- One sub-module, fft_pingpong_ram:
  - Two banks of N x 2*DW words.
  - One synchronous write port and one synchronous read port, selected by bank bits.
  - No reset on storage.
- The top level holds the counters, the bank pointers, the FSM and the output register.

Test Plan:
- Impulse: frame with bin 0 = (100, -100), all others 0, fed in bit-reversed order -> out_sof with (100, -100) at t+2, then 255 zeros, out_eof on the 256th output.
- Index ramp: sample at bit-reversed position k carries re = bitrev(k), im = -bitrev(k) -> outputs re = 0, 1, ..., 255 in order, contiguous, out_valid held 256 cycles.
- Back-to-back: 4 frames with no gaps, frame f re = f*256 + bin -> 1024 contiguous outputs with no bubble; out_sof/out_eof at frame boundaries.
- Gapped input: in_valid 50% random duty -> identical output values to the ramp test; output burst still contiguous, starting 2 cycles after the last input.
- Resync: in_sof asserted at wcnt = 37 -> frame_err pulse, partial frame discarded; next 256 samples produce one correct frame.
- Reset mid-read: RST asserted during output bin 100 -> out_valid = 0 immediately; a following fresh frame is output correctly. With FFT_REORDER_FFTSHIFT_EN, rerun the ramp -> outputs 128..255, 0..127.
